// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM states, bus widths, command record.
// No logic of its own; the width helper sizes the wait counter.
package apb_pkg;

   localparam int APB_ADDR_W      = 32;
   localparam int APB_DATA_W      = 32;
   localparam int APB_STRB_W      = APB_DATA_W / 8;
   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ERRRSP = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] strb;
      logic [2:0]            prot;
   } apb_cmd_t;

   function automatic int wait_cnt_w(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter; expired flags that the next increment reaches limit (0 = never).
// Single-cycle, combinational expired from registered count; no backpressure.
module apb_wait_timer #(
   parameter int W = 5
) (
   input  logic         pclk,
   input  logic         presetn,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W:0]   cnt_nxt;

   assign cnt_nxt = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_nxt[W-1:0];
      end
   end

   // Looks one increment ahead so the abort lands on the cycle the count hits limit.
   assign expired = (limit != '0) && (cnt_nxt >= {1'b0, limit});

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: command in, one SETUP + ACCESS transfer, one-cycle response pulse.
// Latency 3+waits (2 for misaligned, 2+TIMEOUT on abort); cmd_ready only in IDLE, completer stalls via pready.
module apb_requester
   import apb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [APB_ADDR_W-1:0] cmd_addr,
   input  logic [APB_DATA_W-1:0] cmd_wdata,
   input  logic [APB_STRB_W-1:0] cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   output logic [APB_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [APB_ADDR_W-1:0] paddr,
   output logic [APB_DATA_W-1:0] pwdata,
   output logic [APB_STRB_W-1:0] pstrb,
   output logic [2:0]            pprot,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [APB_DATA_W-1:0] prdata,
   output logic                  busy
);

   localparam int                CNT_W = wait_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

   apb_state_e            state_q, state_d;
   apb_cmd_t              cmd_q, cmd_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  tmr_clear, tmr_inc, tmr_expired;

   assign tmr_clear = (state_q == ST_SETUP);
   assign tmr_inc   = (state_q == ST_ACCESS) && !pready;

   apb_wait_timer #(.W(CNT_W)) u_wait_timer (
      .pclk    (pclk),
      .presetn (presetn),
      .clear   (tmr_clear),
      .inc     (tmr_inc),
      .limit   (LIMIT),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_addr[1:0] == 2'b00) begin
                  state_d       = ST_SETUP;
                  cmd_d.write   = cmd_write;
                  cmd_d.addr    = cmd_addr;
                  cmd_d.wdata   = cmd_write ? cmd_wdata : '0;
                  cmd_d.strb    = cmd_write ? cmd_strb : '0;
                  cmd_d.prot    = cmd_prot;
               end else begin
                  state_d = ST_ERRRSP;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // pready is checked first so a late completer still beats the timeout.
            if (pready) begin
               state_d       = ST_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = cmd_q.write ? '0 : prdata;
            end else if (tmr_expired) begin
               state_d       = ST_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end
         end
         ST_ERRRSP: begin
            state_d       = ST_IDLE;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= ST_IDLE;
         cmd_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign penable     = (state_q == ST_ACCESS);
   assign pwrite      = cmd_q.write;
   assign paddr       = cmd_q.addr;
   assign pwdata      = cmd_q.wdata;
   assign pstrb       = cmd_q.strb;
   assign pprot       = cmd_q.prot;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
